// File: rtl/mask_merge.sv
// Field mask/merge stage: rotates the incoming byte into an L-bit field at pos and merges it into dest_in or zero-fills around it.
// Optional parity output is enabled with `define MASK_MERGE_PARITY_EN.
module mask_merge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_hazard,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] rotate_in,
    input  logic [WIDTH-1:0] dest_in,
    input  logic [2:0]       L,
    input  logic [2:0]       pos,
    input  logic             merge_en,
    output logic [WIDTH-1:0] merge_out,
    output logic             valid_out
`ifdef MASK_MERGE_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    logic [3:0]         len_next;
    logic [2*WIDTH-1:0] rot_wide;
    logic [WIDTH-1:0]   shifted_next;
    logic [WIDTH-1:0]   mask_next;

    logic [WIDTH-1:0]   shifted_reg;
    logic [WIDTH-1:0]   mask_reg;
    logic [WIDTH-1:0]   dest_reg;
    logic               merge_en_reg;
    logic               valid_reg;
    logic [WIDTH-1:0]   merge_next;

    // L of zero encodes a full-width field
    assign len_next = (L == 3'd0) ? 4'd8 : {1'b0, L};

    // Left-rotate: upper half of the doubled byte shifted by pos
    assign rot_wide     = {rotate_in, rotate_in} << pos;
    assign shifted_next = rot_wide[2*WIDTH-1:WIDTH];

    // Offset wraps modulo 8 so fields crossing bit 7 continue at bit 0
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            logic [2:0] offset;
            assign offset        = 3'(gi) - pos;
            assign mask_next[gi] = ({1'b0, offset} < len_next);
        end
    endgenerate

    assign merge_next = (shifted_reg & mask_reg)
                      | (merge_en_reg ? (dest_reg & ~mask_reg) : {WIDTH{1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            shifted_reg  <= '0;
            mask_reg     <= '0;
            dest_reg     <= '0;
            merge_en_reg <= 1'b0;
            valid_reg    <= 1'b0;
            merge_out    <= '0;
            valid_out    <= 1'b0;
`ifdef MASK_MERGE_PARITY_EN
            parity_out   <= 1'b0;
`endif
        end else if (!data_hazard) begin
            shifted_reg  <= shifted_next;
            mask_reg     <= mask_next;
            dest_reg     <= dest_in;
            merge_en_reg <= merge_en;
            valid_reg    <= valid_in;
            merge_out    <= merge_next;
            valid_out    <= valid_reg;
`ifdef MASK_MERGE_PARITY_EN
            parity_out   <= ^merge_next;
`endif
        end
    end

endmodule

// File: tb/tb_mask_merge.sv
// Directed-vector bench for mask_merge: full byte, mid field, wrap-around, stall, back-to-back and reset cases.
module tb_mask_merge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_hazard = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] rotate_in = 8'h00;
    logic [7:0] dest_in = 8'h00;
    logic [2:0] L = 3'd0;
    logic [2:0] pos = 3'd0;
    logic       merge_en = 1'b0;
    logic [7:0] merge_out;
    logic       valid_out;
`ifdef MASK_MERGE_PARITY_EN
    logic       parity_out;
`endif

    int passed = 0;
    int total  = 0;

    mask_merge #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_hazard (data_hazard),
        .valid_in    (valid_in),
        .rotate_in   (rotate_in),
        .dest_in     (dest_in),
        .L           (L),
        .pos         (pos),
        .merge_en    (merge_en),
        .merge_out   (merge_out),
        .valid_out   (valid_out)
`ifdef MASK_MERGE_PARITY_EN
        ,
        .parity_out  (parity_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] d, input logic [2:0] l,
                         input logic [2:0] p, input logic m, input logic v);
        rotate_in = r;
        dest_in   = d;
        L         = l;
        pos       = p;
        merge_en  = m;
        valid_in  = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        total++;
        if (merge_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", merge_out);
        else passed++;
        total++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out);
        else passed++;
`ifdef MASK_MERGE_PARITY_EN
        total++;
        if (parity_out !== 1'b0) $display("FAIL reset_parity: got %b expected 0", parity_out);
        else passed++;
`endif
        rst = 1'b0;
        tick();
        $display("reset: merge_out=%h valid_out=%b", merge_out, valid_out);
    endtask

    task automatic test_full;
        drive(8'hA5, 8'h3C, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        total++;
        if (valid_out !== 1'b0) $display("FAIL full_latency: valid_out %b expected 0 after one edge", valid_out);
        else passed++;
        tick();
        $display("full: merge_out=%h valid_out=%b", merge_out, valid_out);
        total++;
        if (merge_out !== 8'hA5 || valid_out !== 1'b1)
            $display("FAIL full_data: got %h/%b expected a5/1", merge_out, valid_out);
        else passed++;
`ifdef MASK_MERGE_PARITY_EN
        total++;
        if (parity_out !== 1'b0) $display("FAIL full_parity: got %b expected 0", parity_out);
        else passed++;
`endif
        tick();
        total++;
        if (valid_out !== 1'b0) $display("FAIL full_bubble: valid_out %b expected 0", valid_out);
        else passed++;
    endtask

    task automatic test_mid_field;
        drive(8'h05, 8'hFF, 3'd3, 3'd2, 1'b1, 1'b1);
        tick();
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        $display("mid: merge_out=%h valid_out=%b", merge_out, valid_out);
        total++;
        if (merge_out !== 8'hF7 || valid_out !== 1'b1)
            $display("FAIL mid_data: got %h/%b expected f7/1", merge_out, valid_out);
        else passed++;
`ifdef MASK_MERGE_PARITY_EN
        total++;
        if (parity_out !== 1'b1) $display("FAIL mid_parity: got %b expected 1", parity_out);
        else passed++;
`endif
    endtask

    task automatic test_wrap;
        drive(8'h0F, 8'h55, 3'd4, 3'd6, 1'b0, 1'b1);
        tick();
        drive(8'h0F, 8'h55, 3'd4, 3'd6, 1'b1, 1'b1);
        tick();
        $display("wrap zero-fill: merge_out=%h valid_out=%b", merge_out, valid_out);
        total++;
        if (merge_out !== 8'hC3 || valid_out !== 1'b1)
            $display("FAIL wrap_zero: got %h/%b expected c3/1", merge_out, valid_out);
        else passed++;
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        $display("wrap merge: merge_out=%h valid_out=%b", merge_out, valid_out);
        total++;
        if (merge_out !== 8'hD7 || valid_out !== 1'b1)
            $display("FAIL wrap_merge: got %h/%b expected d7/1", merge_out, valid_out);
        else passed++;
        tick();
    endtask

    task automatic test_stall;
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        drive(8'h05, 8'hFF, 3'd3, 3'd2, 1'b1, 1'b1);
        tick();
        total++;
        if (merge_out !== 8'h00 || valid_out !== 1'b0)
            $display("FAIL stall_pre: got %h/%b expected 00/0", merge_out, valid_out);
        else passed++;
        data_hazard = 1'b1;
        drive(8'hFF, 8'hFF, 3'd0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (merge_out !== 8'h00 || valid_out !== 1'b0)
                $display("FAIL stall_hold%0d: got %h/%b expected 00/0", i, merge_out, valid_out);
            else passed++;
        end
        data_hazard = 1'b0;
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        $display("stall release: merge_out=%h valid_out=%b", merge_out, valid_out);
        total++;
        if (merge_out !== 8'hF7 || valid_out !== 1'b1)
            $display("FAIL stall_release: got %h/%b expected f7/1", merge_out, valid_out);
        else passed++;
        data_hazard = 1'b1;
        tick();
        total++;
        if (merge_out !== 8'hF7 || valid_out !== 1'b1)
            $display("FAIL stall_valid_hold: got %h/%b expected f7/1", merge_out, valid_out);
        else passed++;
        data_hazard = 1'b0;
        tick();
        total++;
        if (merge_out !== 8'h00 || valid_out !== 1'b0)
            $display("FAIL stall_after: got %h/%b expected 00/0", merge_out, valid_out);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_data [3];
        exp_data[0] = 8'hA5;
        exp_data[1] = 8'hF7;
        exp_data[2] = 8'hD7;
        drive(8'hA5, 8'h3C, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        drive(8'h05, 8'hFF, 3'd3, 3'd2, 1'b1, 1'b1);
        tick();
        total++;
        if (merge_out !== exp_data[0] || valid_out !== 1'b1)
            $display("FAIL b2b_0: got %h/%b expected %h/1", merge_out, valid_out, exp_data[0]);
        else passed++;
        drive(8'h0F, 8'h55, 3'd4, 3'd6, 1'b1, 1'b1);
        tick();
        total++;
        if (merge_out !== exp_data[1] || valid_out !== 1'b1)
            $display("FAIL b2b_1: got %h/%b expected %h/1", merge_out, valid_out, exp_data[1]);
        else passed++;
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        total++;
        if (merge_out !== exp_data[2] || valid_out !== 1'b1)
            $display("FAIL b2b_2: got %h/%b expected %h/1", merge_out, valid_out, exp_data[2]);
        else passed++;
        tick();
        $display("back-to-back: trailing valid_out=%b", valid_out);
        total++;
        if (valid_out !== 1'b0) $display("FAIL b2b_end: valid_out %b expected 0", valid_out);
        else passed++;
    endtask

    task automatic test_reset_mid_op;
        drive(8'hA5, 8'h3C, 3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        total++;
        if (merge_out !== 8'h00 || valid_out !== 1'b0)
            $display("FAIL rstmid_now: got %h/%b expected 00/0", merge_out, valid_out);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (merge_out !== 8'h00 || valid_out !== 1'b0)
                $display("FAIL rstmid_after%0d: got %h/%b expected 00/0", i, merge_out, valid_out);
            else passed++;
        end
        $display("reset mid-op: merge_out=%h valid_out=%b", merge_out, valid_out);
    endtask

    initial begin
        test_reset();
        test_full();
        test_mid_field();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mask_merge.md
Name: mask_merge

Overview:
- Pipeline stage directly downstream of the CPU's right-rotate stage. Consumes its registered rotated byte one cycle after R is applied.
- Builds an L-bit field mask at bit position pos, shifts the rotated data into that field, and either merges it into a destination byte (IV-bus write) or zero-fills outside the field.
- Two register stages, shares the data_hazard stall with the rotate stage; result feeds the writeback/IV-bus output path.

Parameters:
- WIDTH, 8, data width; must remain 8 (L/pos encodings assume 3-bit fields).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- data_hazard  input  1  stall; when 1 all pipeline registers hold
- valid_in  input  1  operation present on inputs this cycle
- rotate_in  input  8  rotated source byte from the rotate stage
- dest_in  input  8  current destination byte to merge into
- L  input  3  field length; 3'b000 means 8 bits, else 1..7
- pos  input  3  field LSB position, 0..7
- merge_en  input  1  1 = merge into dest_in, 0 = zero outside field
- merge_out  output  8  registered result
- valid_out  output  1  merge_out holds a new result this cycle

Behaviour:
- Reset: rst=1 at a clock edge clears every stage-1 and stage-2 register; merge_out=8'h00, valid_out=0. rst overrides data_hazard.
- len = (L==0) ? 8 : L.
- shifted = rotate_in rotated LEFT by pos (bits leaving bit 7 re-enter at bit 0).
- mask bit i = 1 iff ((i - pos) mod 8) < len. Fields crossing bit 7 wrap into bit 0. len=8 gives 8'hFF for any pos.
- Stage 1 (edge N, data_hazard=0): register shifted, mask, dest_in, merge_en, valid_in.
- Stage 2 (edge N+1, data_hazard=0): merge_out = (s_shifted & s_mask) | (merge_en_r ? (s_dest & ~s_mask) : 8'h00); valid_out = stage-1 valid.
- Latency: exactly 2 unstalled edges from valid_in to valid_out. Throughput: 1 op per cycle.
- Stall: data_hazard=1 freezes both stages, including merge_out and valid_out. Inputs presented during the stall are dropped. valid_out stays asserted for the whole stall if it was 1.
- Bubbles: valid_in=0 propagates as valid_out=0.
  - merge_out is still updated with the computed value; consumers must qualify it with valid_out.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro MASK_MERGE_PARITY_EN.
- Defined: adds output parity_out (1 bit) = XOR-reduce of the stage-2 merge_out value. Registered in stage 2 alongside merge_out, same stall and reset behaviour, reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Full byte: rotate_in=8'hA5, L=0, pos=0, dest_in=8'h3C, merge_en=1, valid_in=1 -> two edges later merge_out=8'hA5, valid_out=1 (parity_out=0 if enabled).
- Mid field: rotate_in=8'h05, L=3, pos=2, dest_in=8'hFF, merge_en=1 -> mask 8'h1C, merge_out=8'hF7 (parity_out=1).
- Wrap-around: rotate_in=8'h0F, L=4, pos=6, dest_in=8'h55, merge_en=0 -> shifted=8'hC3, mask=8'hC3, merge_out=8'hC3.
  - Same stimulus with merge_en=1 -> merge_out=8'hD7.
- Stall: issue the mid-field case, hold data_hazard=1 for 2 cycles right after stage 1 captures it; drive rotate_in=8'hFF during the stall -> merge_out/valid_out unchanged through the stall, 8'hF7 valid one edge after release, 8'hFF never appears.
- Back-to-back: three consecutive valid ops (A5/L0, 05/L3/pos2, 0F/L4/pos6, merge_en=1, dest 3C/FF/55) -> valid_out high 3 consecutive cycles with 8'hA5, 8'hF7, 8'hD7.
- Reset mid-operation: valid_in=1 at edge N, rst=1 at edge N+1 -> valid_out stays 0, merge_out=8'h00, no result emerges afterwards.
